// File: rtl/gtp_drp_master_if.sv
// Command/response handshake bundle between fabric test logic and the DRP master.
// The master modport is the command issuer; the slave modport is the DRP master block.
interface gtp_drp_master_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
  );
endinterface

// File: rtl/gtp_drp_master.sv
// DRP initiator for a GTPE2_CHANNEL: read, write and read-modify-write with an
// rdy timeout; one access outstanding, every output driven straight from a flop.
module gtp_drp_master #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  gtp_drp_master_if.slave   bus,
  output logic              drp_en,
  output logic              drp_we,
  output logic [ADDR_W-1:0] drp_addr,
  output logic [DATA_W-1:0] drp_di,
  input  logic [DATA_W-1:0] drp_do,
  input  logic              drp_rdy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_EN, S_RD_WAIT, S_WR_EN, S_WR_WAIT, S_RSP
  } state_t;

  localparam int CNT_W = 10;
  // Counter reads k-1 in wait cycle k, so the last permitted wait cycle sees TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              rmw_q, rmw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drp_en_q, drp_en_d;
  logic              drp_we_q, drp_we_d;
  logic [ADDR_W-1:0] drp_addr_q, drp_addr_d;
  logic [DATA_W-1:0] drp_di_q, drp_di_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rmw_q         <= 1'b0;
      wdata_q       <= '0;
      mask_q        <= '0;
      cnt_q         <= '0;
      drp_en_q      <= 1'b0;
      drp_we_q      <= 1'b0;
      drp_addr_q    <= '0;
      drp_di_q      <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rmw_q         <= rmw_d;
      wdata_q       <= wdata_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      drp_en_q      <= drp_en_d;
      drp_we_q      <= drp_we_d;
      drp_addr_q    <= drp_addr_d;
      drp_di_q      <= drp_di_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rmw_d         = rmw_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    drp_en_d      = 1'b0;
    drp_we_d      = 1'b0;
    drp_addr_d    = drp_addr_q;
    drp_di_d      = drp_di_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          rmw_d         = (bus.cmd_op == 2'b10);
          wdata_d       = bus.cmd_wdata;
          mask_d        = bus.cmd_mask;
          drp_addr_d    = bus.cmd_addr;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b0;
          cnt_d         = '0;
          drp_en_d      = 1'b1;
          // Reserved op 11 falls through to the read path.
          if (bus.cmd_op == 2'b01) begin
            drp_we_d = 1'b1;
            drp_di_d = bus.cmd_wdata;
            state_d  = S_WR_EN;
          end else begin
            state_d  = S_RD_EN;
          end
        end
      end
      S_RD_EN: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (drp_rdy) begin
          rsp_rdata_d = drp_do;
          if (rmw_q) begin
            drp_di_d = (drp_do & ~mask_q) | (wdata_q & mask_q);
            drp_en_d = 1'b1;
            drp_we_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_WR_EN;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = S_RSP;
          end
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_RSP;
        end
      end
      S_WR_EN: begin
        cnt_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (drp_rdy) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  assign drp_en          = drp_en_q;
  assign drp_we          = drp_we_q;
  assign drp_addr        = drp_addr_q;
  assign drp_di          = drp_di_q;
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_gtp_drp_master.sv
// Scoreboard bench: a reference model predicts responses and DRP pulses per command,
// a channel model answers DRP accesses, and a monitor checks each response as it appears.
module tb_gtp_drp_master;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drp_en, drp_we;
  logic [AW-1:0] drp_addr;
  logic [DW-1:0] drp_di;
  logic [DW-1:0] drp_do = '0;
  logic          drp_rdy = 1'b0;

  gtp_drp_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  gtp_drp_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drp_en   (drp_en),
    .drp_we   (drp_we),
    .drp_addr (drp_addr),
    .drp_di   (drp_di),
    .drp_do   (drp_do),
    .drp_rdy  (drp_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          tmo;
  } rsp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
    int            delay;      // 0 = channel never answers
    logic          after_rdy;  // rmw write pulse: must follow the read rdy by one cycle
  } drp_t;

  rsp_t          sb_q[$];
  drp_t          drp_q[$];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] dev_mem [512];

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  bit rr_rand  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decides the DRP pulses and the response from op rules alone.
  task automatic model(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] m, input int d1, input int d2, input bit want_rsp);
    rsp_t          r;
    logic [DW-1:0] old_v, new_v;
    if (op == 2'b01) begin
      drp_q.push_back('{we: 1'b1, addr: a, di: wd, delay: d1, after_rdy: 1'b0});
      if (d1 != 0) ref_mem[a] = wd;
      r = '{rdata: '0, tmo: (d1 == 0)};
    end else begin
      drp_q.push_back('{we: 1'b0, addr: a, di: '0, delay: d1, after_rdy: 1'b0});
      if (d1 == 0) begin
        r = '{rdata: '0, tmo: 1'b1};
      end else if (op != 2'b10) begin
        r = '{rdata: ref_mem[a], tmo: 1'b0};
      end else begin
        old_v = ref_mem[a];
        new_v = (old_v & ~m) | (wd & m);
        drp_q.push_back('{we: 1'b1, addr: a, di: new_v, delay: d2, after_rdy: 1'b1});
        if (d2 != 0) ref_mem[a] = new_v;
        r = '{rdata: old_v, tmo: (d2 == 0)};
      end
    end
    if (want_rsp) sb_q.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] m, input int d1, input int d2, input bit want_rsp);
    int n = 0;
    model(op, a, wd, m, d1, d2, want_rsp);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_mask  = m;
    while (bus.cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 300), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic preset(input logic [AW-1:0] a, input logic [DW-1:0] v);
    ref_mem[a] = v;
    dev_mem[a] = v;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_drp_en"},      32'(drp_en),          32'd0);
    chk({tag, "_drp_we"},      32'(drp_we),          32'd0);
    chk({tag, "_drp_addr"},    32'(drp_addr),        32'd0);
    chk({tag, "_drp_di"},      32'(drp_di),          32'd0);
    chk({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    chk({tag, "_rsp_rdata"},   32'(bus.rsp_rdata),   32'd0);
    chk({tag, "_cmd_ready"},   32'(bus.cmd_ready),   32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) if (rr_rand) bus.rsp_ready = ($urandom_range(0, 3) != 0);

  // Channel model: answers each drp_en after the delay chosen for that pulse.
  bit            pend = 1'b0, p_chk = 1'b0, p_we = 1'b0;
  int            cd = 0, en_cyc = -100, rdy_cyc = -100;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_di = '0;
  always @(negedge clk) begin
    drp_t e;
    #1;
    drp_rdy = 1'b0;
    drp_do  = DW'($urandom);
    if (rst) p_chk = 1'b0;
    if (drp_en === 1'b1) begin
      chk("drp_expected", 32'(drp_q.size() > 0), 32'd1);
      if (drp_q.size() > 0) begin
        e = drp_q.pop_front();
        chk("drp_we", 32'(drp_we), 32'(e.we));
        chk("drp_addr", 32'(drp_addr), 32'(e.addr));
        if (e.we) chk("drp_di", 32'(drp_di), 32'(e.di));
        if (e.after_rdy) chk("rmw_wr_latency", 32'(cyc), 32'(rdy_cyc + 1));
        pend   = (e.delay != 0);
        cd     = e.delay;
        p_chk  = 1'b1;
        p_addr = drp_addr;
        p_di   = drp_di;
        p_we   = drp_we;
        en_cyc = cyc;
      end
    end else if (pend) begin
      if (p_chk) begin
        chk("drp_addr_hold", 32'(drp_addr), 32'(p_addr));
        chk("drp_di_hold", 32'(drp_di), 32'(p_di));
      end
      cd--;
      if (cd == 0) begin
        pend    = 1'b0;
        drp_rdy = 1'b1;
        rdy_cyc = cyc;
        if (p_we) dev_mem[p_addr] = p_di;
        else      drp_do = dev_mem[p_addr];
      end
    end
  end

  // Response monitor: latency on rise, hold under backpressure, data on handshake.
  bit            pv = 1'b0, phs = 1'b0, pto = 1'b0;
  logic [DW-1:0] prd = '0;
  always @(negedge clk) begin
    rsp_t r;
    #2;
    if (rst) begin
      pv  = 1'b0;
      phs = 1'b0;
    end else begin
      if (phs) chk("ready_after_hs", 32'(bus.cmd_ready), 32'd1);
      if (pv && !phs) begin
        chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("hold_rdata", 32'(bus.rsp_rdata), 32'(prd));
        chk("hold_timeout", 32'(bus.rsp_timeout), 32'(pto));
      end
      if (bus.rsp_valid === 1'b1) begin
        chk("busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        if (!pv) begin
          chk("rsp_expected", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            if (sb_q[0].tmo) chk("tmo_latency", 32'(cyc), 32'(en_cyc + TO + 1));
            else             chk("rdy_latency", 32'(cyc), 32'(rdy_cyc + 1));
          end
        end
        if (bus.rsp_ready === 1'b1 && sb_q.size() > 0) begin
          r = sb_q.pop_front();
          n_rsp++;
          $display("rsp %0d: rdata=%h timeout=%0b (exp %h/%0b)",
                   n_rsp, bus.rsp_rdata, bus.rsp_timeout, r.rdata, r.tmo);
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
          chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(r.tmo));
        end
      end
      pv  = (bus.rsp_valid === 1'b1);
      phs = (bus.rsp_valid === 1'b1) && (bus.rsp_ready === 1'b1);
      prd = bus.rsp_rdata;
      pto = bus.rsp_timeout;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_mask  = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 512; i++) preset(AW'(i), DW'($urandom));

    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    preset(9'h05F, 16'hA5C3);
    send(2'b00, 9'h05F, 16'h0000, 16'h0000, 3, 0, 1'b1);
    send(2'b01, 9'h011, 16'h1234, 16'h0000, 1, 0, 1'b1);
    preset(9'h0A0, 16'hFF00);
    send(2'b10, 9'h0A0, 16'h00AA, 16'h00F0, 2, 2, 1'b1);
    send(2'b00, 9'h0A0, 16'h0000, 16'h0000, 1, 0, 1'b1);
    send(2'b00, 9'h05F, 16'h0000, 16'h0000, 0, 0, 1'b1);
    send(2'b10, 9'h0A0, 16'h5555, 16'hFFFF, 0, 4, 1'b1);
    send(2'b00, 9'h05F, 16'h0000, 16'h0000, TO, 0, 1'b1);
    send(2'b10, 9'h011, 16'hBEEF, 16'h0F0F, TO, TO, 1'b1);
    send(2'b01, 9'h022, 16'hCAFE, 16'h0000, 0, 0, 1'b1);
    send(2'b10, 9'h0A0, 16'h1111, 16'hFF00, 3, 0, 1'b1);
    send(2'b11, 9'h011, 16'h0000, 16'h0000, 2, 0, 1'b1);
    wait_drain();

    // Backpressure: stall the response, with the next command waiting alongside it.
    rr_rand = 1'b0;
    bus.rsp_ready = 1'b0;
    send(2'b00, 9'h05F, 16'h0000, 16'h0000, 2, 0, 1'b1);
    begin
      int n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("bp_rsp_wait", 32'(n < 50), 32'd1);
    end
    fork
      send(2'b01, 9'h033, 16'h7777, 16'h0000, 1, 0, 1'b1);
      begin
        repeat (5) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        rr_rand = 1'b1;
      end
    join
    wait_drain();

    // Reset in RD_WAIT with the channel answering after the reset.
    send(2'b00, 9'h033, 16'h0000, 16'h0000, 6, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midop_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_idle("after_late_rdy");
    send(2'b00, 9'h033, 16'h0000, 16'h0000, 2, 0, 1'b1);
    wait_drain();

    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), DW'($urandom), DW'($urandom),
           int'($urandom_range(0, TO)), int'($urandom_range(0, TO)), 1'b1);
    end
    wait_drain();
    chk("drp_q_empty", 32'(drp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
